wb_arbiter: RTL
===============

# wb_arbiter

Round-robin Wishbone B4 arbiter that lets NMASTERS bus masters share one slave port. In the CPU testbench it sits between the core's instruction and data ports and the downstream `mux_switch`/RAM, so a single-port memory can serve both. It holds each grant for the master's whole `cyc` window, including cti bursts. A per-access watchdog aborts hung slaves with `err`.

## Interface
Parameters:
- `NMASTERS`, default 2: number of masters, legal range 2..4.
- `TIMEOUT`, default 255: cycles a strobed access may wait for `ack`/`err` before abort. 0 disables the watchdog.

Ports (master vectors are packed with master i at slice i):
- `clk`  in  1  system clock
- `rst`  in  1  reset. One clock domain; reset is synchronous and active-high.
- `master_addr`  in  NMASTERS*32  addresses
- `master_wdata`  in  NMASTERS*32  write data
- `master_sel`  in  NMASTERS*4  byte selects
- `master_we`  in  NMASTERS  write enables
- `master_cyc`  in  NMASTERS  cycle requests
- `master_stb`  in  NMASTERS  strobes
- `master_cti`  in  NMASTERS*3  cycle type
- `master_bte`  in  NMASTERS*2  burst type
- `master_rdata`  out  32  read data, broadcast to all masters
- `master_ack`  out  NMASTERS  per-master ack
- `master_err`  out  NMASTERS  per-master err
- `slave_addr`, `slave_wdata`, `slave_sel`, `slave_we`, `slave_cti`, `slave_bte`  out  32/32/4/1/3/2  granted master's signals
- `slave_cyc`, `slave_stb`  out  1  gated request
- `slave_rdata`  in  32  slave read data
- `slave_ack`, `slave_err`  in  1  slave response
- `grant`  out  NMASTERS  one-hot current owner, for debug and snoop

## Operation
- State machine with three states: IDLE, OWN, ABORT.
- IDLE:
  - `grant`=0, `slave_cyc`=`slave_stb`=0.
  - If any `master_cyc` is high, pick the first requester searching from `last+1` (wrapping modulo NMASTERS).
  - Register the pick into `grant` and `last`, then go to OWN.
- OWN:
  - Slave outputs mux combinationally from the granted master; `slave_cyc`/`slave_stb` follow that master's `cyc`/`stb`.
  - `slave_ack`/`slave_err` route only to the granted master's bit; all other `master_ack`/`master_err` bits are 0.
  - Granted `master_cyc` low → IDLE. Other masters' requests never preempt the owner, including mid-burst (cti 3'b010).
- Watchdog:
  - Counter clears on entering OWN and on every `slave_ack`/`slave_err`.
  - Increments while `slave_stb` is high.
  - On reaching TIMEOUT: pulse `master_err[grant]` for 1 cycle and go to ABORT.
- ABORT:
  - `slave_cyc`=`slave_stb`=0, grant is held.
  - Leave to IDLE when the granted `master_cyc` goes low.
  - Late `slave_ack`/`slave_err` arriving in ABORT is dropped.
- Non-granted masters are simply stalled: no ack, no err.

## Timing
- Reset values: state IDLE, `grant`=0, `last`=NMASTERS-1 (master 0 wins first), watchdog counter 0.
- Every output is 0 in reset, except `master_rdata`, which passes `slave_rdata` through.
- Arbitration latency: `cyc` seen in IDLE at cycle n → `grant` and `slave_cyc` asserted at n+1.
- OWN-path `ack`/`err`/`rdata` are combinational: zero added latency after the grant.
- Release: owner drops `cyc` at cycle n → IDLE at n+1 → next grant at n+2. This one-cycle bubble is mandatory even when another master is waiting.
- Simultaneous requests from several masters in IDLE: exactly one grant, chosen by round-robin order.
- `slave_ack` in the same cycle the watchdog would expire: the ack wins, the counter clears, and no err is issued.
- `rst` mid-transaction: next cycle is IDLE with all request outputs 0; any in-flight slave response is ignored.

## Structure
- Shared `bellatrix_bus_pkg`:
  - cti constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111) and bte constants.
  - State enum (IDLE/OWN/ABORT).
- One sub-module, `rr_picker`: combinational round-robin. Inputs are request vector + `last`; output is one-hot winner plus a valid flag.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates.

## Test plan
- Reset, then master 0 reads `0x8000_0000` with RAM acking 1 cycle later → `grant`=2'b01 one cycle after `cyc`, `master_ack[0]` pulses, `master_ack[1]` stays 0.
- Both masters raise `cyc` in the same cycle after reset → master 0 served first. Master 1 is granted exactly 2 cycles after master 0 drops `cyc`. Next contention → master 1 is not picked twice in a row unless master 0 is idle.
- Master 0 runs a 4-beat INCR burst (cti 010,010,010,111) while master 1 requests → 4 acks to master 0 with no grant change; master 1 is granted after the bubble.
- Slave never acks, TIMEOUT=8 → `master_err` pulses exactly 8 strobed cycles after the grant; `slave_cyc` is 0 the following cycle and remains 0 until master releases.
- `slave_ack` lands on the same cycle the counter reaches TIMEOUT → `ack` delivered, no `err`, state stays OWN.
- Assert `rst` for 1 cycle while master 1 owns the bus mid-write → next cycle `grant`=0 and `slave_cyc`=0. Next arbitration with both masters requesting favors master 0.

Source files
------------

// File: rtl/bellatrix_bus_pkg.sv
// Shared Wishbone B4 bus definitions: cycle/burst type encodings and arbiter state.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bellatrix_bus_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: first requester searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is present.
module rr_picker #(
    parameter int N  = 2,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  winner,
    output logic          vld
);

    always_comb begin
        winner = '0;
        vld    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!vld && req[(int'(last) + k) % N]) begin
                winner[(int'(last) + k) % N] = 1'b1;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: NMASTERS masters onto one slave, grant held for the whole cyc window.
// Latency: grant one cycle after cyc seen in IDLE; ack/err/rdata combinational while owning.
// Backpressure: non-granted masters stall (no ack/err); hung slaves are aborted by a watchdog with err.
module wb_arbiter
    import bellatrix_bus_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NMASTERS*32-1:0]  master_addr,
    input  logic [NMASTERS*32-1:0]  master_wdata,
    input  logic [NMASTERS*4-1:0]   master_sel,
    input  logic [NMASTERS-1:0]     master_we,
    input  logic [NMASTERS-1:0]     master_cyc,
    input  logic [NMASTERS-1:0]     master_stb,
    input  logic [NMASTERS*3-1:0]   master_cti,
    input  logic [NMASTERS*2-1:0]   master_bte,
    output logic [31:0]             master_rdata,
    output logic [NMASTERS-1:0]     master_ack,
    output logic [NMASTERS-1:0]     master_err,
    output logic [31:0]             slave_addr,
    output logic [31:0]             slave_wdata,
    output logic [3:0]              slave_sel,
    output logic                    slave_we,
    output logic [2:0]              slave_cti,
    output logic [1:0]              slave_bte,
    output logic                    slave_cyc,
    output logic                    slave_stb,
    input  logic [31:0]             slave_rdata,
    input  logic                    slave_ack,
    input  logic                    slave_err,
    output logic [NMASTERS-1:0]     grant
);

    localparam int LW = $clog2(NMASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    arb_state_t          state_q, state_nxt;
    logic [NMASTERS-1:0] grant_q, grant_nxt;
    logic [LW-1:0]       last_q, last_nxt;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic [NMASTERS-1:0] pick;
    logic                pick_vld;
    logic [LW-1:0]       pick_idx;
    logic [LW-1:0]       gidx;
    logic                own_cyc;
    logic                own_stb;
    logic                owning;
    logic                expire;

    rr_picker #(
        .N  (NMASTERS),
        .LW (LW)
    ) u_picker (
        .req    (master_cyc),
        .last   (last_q),
        .winner (pick),
        .vld    (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        gidx     = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (pick[i])    pick_idx = LW'(i);
            if (grant_q[i]) gidx     = LW'(i);
        end
    end

    assign own_cyc = master_cyc[gidx];
    assign own_stb = master_stb[gidx];
    // Reset gates everything so a response arriving during rst never reaches a master.
    assign owning  = (state_q == OWN) && !rst;
    // Expiry is judged on the registered count so a same-cycle ack always wins.
    assign expire  = owning && (TIMEOUT != 0) && own_cyc && own_stb &&
                     (cnt_q == TO_VAL) && !slave_ack && !slave_err;

    assign master_rdata = slave_rdata;
    assign grant        = rst ? '0 : grant_q;

    always_comb begin
        slave_addr  = '0;
        slave_wdata = '0;
        slave_sel   = '0;
        slave_we    = 1'b0;
        slave_cti   = '0;
        slave_bte   = '0;
        slave_cyc   = 1'b0;
        slave_stb   = 1'b0;
        master_ack  = '0;
        master_err  = '0;
        if (owning) begin
            slave_addr  = master_addr[int'(gidx)*32 +: 32];
            slave_wdata = master_wdata[int'(gidx)*32 +: 32];
            slave_sel   = master_sel[int'(gidx)*4 +: 4];
            slave_we    = master_we[gidx];
            slave_cti   = master_cti[int'(gidx)*3 +: 3];
            slave_bte   = master_bte[int'(gidx)*2 +: 2];
            slave_cyc   = own_cyc;
            slave_stb   = own_stb;
            master_ack  = grant_q & {NMASTERS{slave_ack}};
            master_err  = grant_q & {NMASTERS{slave_err | expire}};
        end
    end

    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_nxt = '0;
                cnt_nxt   = '0;
                if (pick_vld) begin
                    state_nxt = OWN;
                    grant_nxt = pick;
                    last_nxt  = pick_idx;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                end else if (expire) begin
                    state_nxt = ABORT;
                    cnt_nxt   = '0;
                end else if (slave_ack || slave_err) begin
                    cnt_nxt = '0;
                end else if (own_stb && (cnt_q != TO_VAL)) begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                cnt_nxt = '0;
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NMASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule
